// File: rtl/cerradura_pkg.sv
// Shared types and key codes for the keypad code lock.
package cerradura_pkg;

    typedef enum logic [1:0] {
        ENTRADA  = 2'd0,
        ABIERTO  = 2'd1,
        PROGRAMA = 2'd2,
        BLOQUEO  = 2'd3
    } estado_t;

    localparam logic [3:0] KEY_PROG    = 4'hA;
    localparam logic [3:0] KEY_BORRAR  = 4'hB;
    localparam logic [3:0] KEY_LIMPIAR = 4'hC;
    localparam logic [3:0] KEY_ENTER   = 4'hD;
    localparam logic [3:0] KEY_NULA    = 4'hF;

    function automatic logic es_digito(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/cerradura_teclado_detector_liberacion.sv
// One key event per press: the scanner's repeated pulses only count again
// after key_detected has stayed low for RELEASE_CYCLES consecutive cycles.
module detector_liberacion
    import cerradura_pkg::*;
#(
    parameter int RELEASE_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_detected,
    input  logic [3:0] digito,
    output logic       evento,
    output logic [3:0] evento_codigo
);

    localparam int RW = $clog2(RELEASE_CYCLES + 1);
    localparam logic [RW-1:0] ULTIMO = RW'(RELEASE_CYCLES - 1);

    logic          armado;
    logic [RW-1:0] cuenta;

    assign evento        = armado & key_detected;
    assign evento_codigo = digito;

    always_ff @(posedge clk) begin
        if (!rst) begin
            armado <= 1'b1;
            cuenta <= '0;
        end else if (armado) begin
            if (key_detected) armado <= 1'b0;
            cuenta <= '0;
        end else if (key_detected) begin
            cuenta <= '0;
        end else if (cuenta == ULTIMO) begin
            // this edge brings the low-cycle count up to RELEASE_CYCLES
            armado <= 1'b1;
            cuenta <= '0;
        end else begin
            cuenta <= cuenta + RW'(1);
        end
    end

endmodule

// File: rtl/cerradura_teclado.sv
// 4-digit keypad code lock: entry buffer, stored code, programming,
// and a timed lockout after repeated wrong codes.
module cerradura_teclado
    import cerradura_pkg::*;
#(
    parameter logic [15:0] CODE           = 16'h1234,
    parameter int          RELEASE_CYCLES = 1500000,
    parameter int          MAX_FAILS      = 3,
    parameter int          LOCKOUT_CYCLES = 250000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  digito,
    input  logic        key_detected,
    output logic [15:0] buffer,
    output logic [2:0]  num_digits,
    output logic        abierto,
    output logic        bloqueado,
    output logic        error,
    output logic        guardado,
    output logic [1:0]  estado
);

    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [FW-1:0] MAXF  = FW'(MAX_FAILS);
    localparam logic [TW-1:0] TLOAD = TW'(LOCKOUT_CYCLES - 1);

    logic       evento;
    logic [3:0] k;

    detector_liberacion #(
        .RELEASE_CYCLES(RELEASE_CYCLES)
    ) u_detector (
        .clk          (clk),
        .rst          (rst),
        .key_detected (key_detected),
        .digito       (digito),
        .evento       (evento),
        .evento_codigo(k)
    );

    estado_t        estado_q, estado_n;
    logic [15:0]    buffer_q, buffer_n;
    logic [2:0]     num_q, num_n;
    logic [15:0]    code_q, code_n;
    logic [FW-1:0]  fails_q, fails_n, fails_inc;
    logic [TW-1:0]  timer_q, timer_n;
    logic           error_q, error_n;
    logic           guardado_q, guardado_n;
    logic           edicion;

    always_ff @(posedge clk) begin
        if (!rst) begin
            estado_q   <= ENTRADA;
            buffer_q   <= '0;
            num_q      <= '0;
            code_q     <= CODE;
            fails_q    <= '0;
            timer_q    <= '0;
            error_q    <= 1'b0;
            guardado_q <= 1'b0;
        end else begin
            estado_q   <= estado_n;
            buffer_q   <= buffer_n;
            num_q      <= num_n;
            code_q     <= code_n;
            fails_q    <= fails_n;
            timer_q    <= timer_n;
            error_q    <= error_n;
            guardado_q <= guardado_n;
        end
    end

    always_comb begin
        estado_n   = estado_q;
        buffer_n   = buffer_q;
        num_n      = num_q;
        code_n     = code_q;
        fails_n    = fails_q;
        timer_n    = timer_q;
        error_n    = 1'b0;
        guardado_n = 1'b0;
        fails_inc  = (fails_q == MAXF) ? fails_q : fails_q + FW'(1);
        edicion    = evento &&
                     (estado_q == ENTRADA || estado_q == PROGRAMA);

        if (edicion) begin
            unique case (1'b1)
                es_digito(k): begin
                    if (num_q < 3'd4) begin
                        buffer_n = {buffer_q[11:0], k};
                        num_n    = num_q + 3'd1;
                    end
                end
                (k == KEY_BORRAR): begin
                    if (num_q != 3'd0) begin
                        buffer_n = {4'h0, buffer_q[15:4]};
                        num_n    = num_q - 3'd1;
                    end
                end
                (k == KEY_LIMPIAR): begin
                    buffer_n = '0;
                    num_n    = '0;
                end
                default: ;
            endcase
        end

        unique case (estado_q)
            ENTRADA: begin
                if (evento && k == KEY_ENTER) begin
                    buffer_n = '0;
                    num_n    = '0;
                    if (num_q != 3'd4) begin
                        error_n = 1'b1;
                    end else if (buffer_q == code_q) begin
                        estado_n = ABIERTO;
                        fails_n  = '0;
                    end else begin
                        error_n = 1'b1;
                        fails_n = fails_inc;
                        if (fails_inc == MAXF) begin
                            estado_n = BLOQUEO;
                            timer_n  = TLOAD;
                            fails_n  = '0;
                        end
                    end
                end
            end
            ABIERTO: begin
                if (evento && (k == KEY_ENTER || k == KEY_PROG)) begin
                    buffer_n = '0;
                    num_n    = '0;
                    estado_n = (k == KEY_PROG) ? PROGRAMA : ENTRADA;
                end
            end
            PROGRAMA: begin
                if (evento && k == KEY_ENTER) begin
                    buffer_n = '0;
                    num_n    = '0;
                    if (num_q == 3'd4) begin
                        code_n     = buffer_q;
                        guardado_n = 1'b1;
                        estado_n   = ABIERTO;
                    end else begin
                        error_n = 1'b1;
                    end
                end else if (evento && k == KEY_PROG) begin
                    buffer_n = '0;
                    num_n    = '0;
                    estado_n = ABIERTO;
                end
            end
            BLOQUEO: begin
                // timer holds LOCKOUT_CYCLES-1 on entry, so the lock
                // stays shut for exactly LOCKOUT_CYCLES cycles
                if (timer_q == '0) estado_n = ENTRADA;
                else timer_n = timer_q - TW'(1);
            end
            default: ;
        endcase
    end

    assign buffer     = buffer_q;
    assign num_digits = num_q;
    assign abierto    = (estado_q == ABIERTO) || (estado_q == PROGRAMA);
    assign bloqueado  = (estado_q == BLOQUEO);
    assign error      = error_q;
    assign guardado   = guardado_q;
    assign estado     = estado_q;

endmodule

// File: tb/tb_cerradura_teclado.sv
// Directed bench for cerradura_teclado with short release/lockout times.
module tb_cerradura_teclado;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  digito = 4'hF;
    logic        key_detected = 1'b0;
    logic [15:0] buffer;
    logic [2:0]  num_digits;
    logic        abierto, bloqueado, error, guardado;
    logic [1:0]  estado;

    int errors = 0;
    int checks = 0;
    logic err_seen, grd_seen;

    cerradura_teclado #(
        .CODE(16'h1234),
        .RELEASE_CYCLES(4),
        .MAX_FAILS(3),
        .LOCKOUT_CYCLES(20)
    ) dut (
        .clk(clk), .rst(rst), .digito(digito),
        .key_detected(key_detected), .buffer(buffer),
        .num_digits(num_digits), .abierto(abierto),
        .bloqueado(bloqueado), .error(error),
        .guardado(guardado), .estado(estado)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // one accepted press followed by exactly the release gap that re-arms
    task automatic press(input logic [3:0] k);
        digito = k;
        key_detected = 1'b1;
        tick();
        err_seen = error;
        grd_seen = guardado;
        key_detected = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if ({buffer, num_digits, abierto, bloqueado, error, guardado, estado}
            !== 25'd0) begin
            $display("FAIL reset: got buf=%h n=%0d ab=%b bl=%b er=%b gd=%b st=%0d exp all 0",
                     buffer, num_digits, abierto, bloqueado, error, guardado, estado);
            errors++;
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_hold;
        digito = 4'h5;
        key_detected = 1'b1;
        repeat (10) tick();
        key_detected = 1'b0;
        repeat (4) tick();
        key_detected = 1'b1;
        tick();
        key_detected = 1'b0;
        repeat (4) tick();
        checks++;
        if (buffer !== 16'h0055 || num_digits !== 3'd2) begin
            $display("FAIL hold_gap4: got buf=%h n=%0d exp 0055 n=2", buffer, num_digits);
            errors++;
        end
        press(4'hC);
        digito = 4'h5;
        key_detected = 1'b1;
        repeat (10) tick();
        key_detected = 1'b0;
        repeat (3) tick();
        key_detected = 1'b1;
        tick();
        key_detected = 1'b0;
        repeat (4) tick();
        checks++;
        if (buffer !== 16'h0005 || num_digits !== 3'd1) begin
            $display("FAIL hold_gap3: got buf=%h n=%0d exp 0005 n=1", buffer, num_digits);
            errors++;
        end
        press(4'hC);
    endtask

    task automatic test_unlock;
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        checks++;
        if (buffer !== 16'h1234 || num_digits !== 3'd4 || abierto !== 1'b0) begin
            $display("FAIL unlock_entry: got buf=%h n=%0d ab=%b exp 1234 n=4 ab=0",
                     buffer, num_digits, abierto);
            errors++;
        end
        digito = 4'hD;
        key_detected = 1'b1;
        tick();
        checks++;
        if (abierto !== 1'b1 || estado !== 2'd1 || buffer !== 16'h0 || error !== 1'b0) begin
            $display("FAIL unlock_open: got ab=%b st=%0d buf=%h er=%b exp 1 1 0000 0",
                     abierto, estado, buffer, error);
            errors++;
        end
        key_detected = 1'b0;
        repeat (4) tick();
        press(4'h7);
        checks++;
        if (buffer !== 16'h0 || estado !== 2'd1) begin
            $display("FAIL open_ignores_digit: got buf=%h st=%0d exp 0000 1", buffer, estado);
            errors++;
        end
        press(4'hD);
        checks++;
        if (abierto !== 1'b0 || estado !== 2'd0) begin
            $display("FAIL relock: got ab=%b st=%0d exp 0 0", abierto, estado);
            errors++;
        end
    endtask

    task automatic wrong_entry(input string name, input logic exp_lock);
        press(4'h9); press(4'h9); press(4'h9); press(4'h9);
        digito = 4'hD;
        key_detected = 1'b1;
        tick();
        checks++;
        if (error !== 1'b1 || bloqueado !== exp_lock || buffer !== 16'h0) begin
            $display("FAIL %s: got er=%b bl=%b buf=%h exp er=1 bl=%b buf=0000",
                     name, error, bloqueado, buffer, exp_lock);
            errors++;
        end
        key_detected = 1'b0;
        tick();
        checks++;
        if (error !== 1'b0) begin
            $display("FAIL %s_pulse_width: got er=%b exp 0", name, error);
            errors++;
        end
        repeat (3) tick();
    endtask

    task automatic test_lockout;
        wrong_entry("wrong1", 1'b0);
        wrong_entry("wrong2", 1'b0);
        wrong_entry("wrong3", 1'b1);
        // D edge was E0; wrong_entry consumed E1..E4
        checks++;
        if (estado !== 2'd3 || abierto !== 1'b0) begin
            $display("FAIL lock_state: got st=%0d ab=%b exp 3 0", estado, abierto);
            errors++;
        end
        press(4'h1);
        press(4'h2);
        checks++;
        if (buffer !== 16'h0 || num_digits !== 3'd0 || bloqueado !== 1'b1) begin
            $display("FAIL lock_ignores: got buf=%h n=%0d bl=%b exp 0000 0 1",
                     buffer, num_digits, bloqueado);
            errors++;
        end
        repeat (5) tick();
        checks++;
        if (bloqueado !== 1'b1 || estado !== 2'd3) begin
            $display("FAIL lock_cycle20: got bl=%b st=%0d exp 1 3", bloqueado, estado);
            errors++;
        end
        press(4'h7);
        checks++;
        if (bloqueado !== 1'b0 || estado !== 2'd0 || buffer !== 16'h0) begin
            $display("FAIL lock_expiry: got bl=%b st=%0d buf=%h exp 0 0 0000",
                     bloqueado, estado, buffer);
            errors++;
        end
        wrong_entry("post_lock1", 1'b0);
        wrong_entry("post_lock2", 1'b0);
        checks++;
        if (estado !== 2'd0) begin
            $display("FAIL fails_cleared: got st=%0d exp 0", estado);
            errors++;
        end
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hD);
        press(4'hD);
    endtask

    task automatic test_program;
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hD);
        press(4'hA);
        checks++;
        if (estado !== 2'd2 || abierto !== 1'b1) begin
            $display("FAIL prog_enter: got st=%0d ab=%b exp 2 1", estado, abierto);
            errors++;
        end
        press(4'h5); press(4'h6); press(4'h7); press(4'h8);
        press(4'hD);
        checks++;
        if (grd_seen !== 1'b1 || err_seen !== 1'b0 || estado !== 2'd1) begin
            $display("FAIL prog_store: got gd=%b er=%b st=%0d exp 1 0 1",
                     grd_seen, err_seen, estado);
            errors++;
        end
        press(4'hD);
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hD);
        checks++;
        if (err_seen !== 1'b1 || abierto !== 1'b0) begin
            $display("FAIL old_code_rejected: got er=%b ab=%b exp 1 0", err_seen, abierto);
            errors++;
        end
        press(4'h5); press(4'h6); press(4'h7); press(4'h8); press(4'hD);
        checks++;
        if (abierto !== 1'b1 || err_seen !== 1'b0) begin
            $display("FAIL new_code_opens: got ab=%b er=%b exp 1 0", abierto, err_seen);
            errors++;
        end
        press(4'hD);
    endtask

    task automatic test_edit;
        press(4'h1); press(4'h2); press(4'h3);
        checks++;
        if (buffer !== 16'h0123 || num_digits !== 3'd3) begin
            $display("FAIL edit_digits: got buf=%h n=%0d exp 0123 3", buffer, num_digits);
            errors++;
        end
        press(4'hB);
        checks++;
        if (buffer !== 16'h0012 || num_digits !== 3'd2) begin
            $display("FAIL edit_back: got buf=%h n=%0d exp 0012 2", buffer, num_digits);
            errors++;
        end
        press(4'hC);
        checks++;
        if (buffer !== 16'h0 || num_digits !== 3'd0) begin
            $display("FAIL edit_clear: got buf=%h n=%0d exp 0000 0", buffer, num_digits);
            errors++;
        end
        press(4'hB);
        checks++;
        if (buffer !== 16'h0 || num_digits !== 3'd0) begin
            $display("FAIL edit_back_empty: got buf=%h n=%0d exp 0000 0", buffer, num_digits);
            errors++;
        end
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
        checks++;
        if (buffer !== 16'h1234 || num_digits !== 3'd4) begin
            $display("FAIL fifth_digit: got buf=%h n=%0d exp 1234 4", buffer, num_digits);
            errors++;
        end
        press(4'hF);
        press(4'hC);
        wrong_entry("edit_wrong", 1'b0);
        press(4'h1);
        press(4'hD);
        checks++;
        if (err_seen !== 1'b1 || buffer !== 16'h0 || estado !== 2'd0) begin
            $display("FAIL short_entry: got er=%b buf=%h st=%0d exp 1 0000 0",
                     err_seen, buffer, estado);
            errors++;
        end
        // short entry must not have counted: this is only the 2nd failure
        wrong_entry("edit_wrong2", 1'b0);
    endtask

    task automatic test_reset_in_prog;
        press(4'h5); press(4'h6); press(4'h7); press(4'h8); press(4'hD);
        press(4'hA);
        press(4'h9); press(4'h9);
        checks++;
        if (estado !== 2'd2 || num_digits !== 3'd2) begin
            $display("FAIL prog_before_reset: got st=%0d n=%0d exp 2 2", estado, num_digits);
            errors++;
        end
        test_reset();
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hD);
        checks++;
        if (abierto !== 1'b1 || err_seen !== 1'b0) begin
            $display("FAIL code_reverted: got ab=%b er=%b exp 1 0", abierto, err_seen);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_unlock();
        test_lockout();
        test_program();
        test_edit();
        test_reset_in_prog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
